// File: rtl/rx_comma_align_if.sv
// rx_comma_align_if -- serial-in / aligned-symbol-out bundle for rx_comma_align.
//   ENB        bit-enable qualifying every clock edge
//   in_serial  8b/10b line bit, MSB of each symbol first
//   out_10b    registered aligned 10-bit symbol
//   valid      one-cycle pulse, out_10b updated this cycle
//   comma_det  qualifies valid; captured symbol is K28.5
//   locked     high while the aligner is locked
// master: the line side that drives the bit stream; slave: the aligner.
interface rx_comma_align_if;
  logic       ENB;
  logic       in_serial;
  logic [9:0] out_10b;
  logic       valid;
  logic       comma_det;
  logic       locked;

  modport master (
    output ENB, in_serial,
    input  out_10b, valid, comma_det, locked
  );

  modport slave (
    input  ENB, in_serial,
    output out_10b, valid, comma_det, locked
  );
endinterface

// File: rtl/rx_comma_align.sv
// rx_comma_align -- K28.5 comma detector and 10-bit symbol aligner.
// Shifts the serial line into a 10-bit window, finds K28.5 in either
// running disparity, acquires alignment after LOCK_CNT aligned commas and
// drops back to search after LOSS_CNT misaligned commas while locked.
// Ports:
//   CLK    single clock, rising edge
//   reset  asynchronous active-high reset
//   bus    rx_comma_align_if.slave (ENB, in_serial in; out_10b, valid,
//          comma_det, locked out)
module rx_comma_align #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4
) (
  input logic             CLK,
  input logic             reset,
  rx_comma_align_if.slave bus
);

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  localparam int CW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int EW = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CNT);
  localparam logic [EW-1:0] LOSS_MAX = EW'(LOSS_CNT);

  typedef enum logic [1:0] {
    SEARCH,
    ACQ,
    LOCKED
  } state_t;

  state_t        state;
  logic [9:0]    sreg;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] comma_cnt;
  logic [CW-1:0] comma_nxt;
  logic [EW-1:0] err_cnt;
  logic [EW-1:0] err_nxt;
  logic [9:0]    out_q;
  logic          valid_q;
  logic          det_q;
  logic          locked_q;
  logic          comma;
  logic          aligned;

  assign comma   = (sreg == K28_5_RDN) || (sreg == K28_5_RDP);
  assign aligned = (bit_cnt == 4'd0);

  // Saturating increments so neither counter can ever wrap.
  assign comma_nxt = (comma_cnt >= LOCK_MAX) ? LOCK_MAX : comma_cnt + CW'(1);
  assign err_nxt   = (err_cnt >= LOSS_MAX) ? LOSS_MAX : err_cnt + EW'(1);

  assign bus.out_10b   = out_q;
  assign bus.valid     = valid_q;
  assign bus.comma_det = det_q;
  assign bus.locked    = locked_q;

  // The comma check looks at sreg before this edge's shift, so the symbol
  // whose last bit arrived on the previous enabled edge is the one captured.
  // A comma found in SEARCH sits at bit position 0 now, hence bit_cnt <= 1.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      sreg      <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      err_cnt   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      det_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      det_q   <= 1'b0;
      if (bus.ENB) begin
        sreg    <= {sreg[8:0], bus.in_serial};
        bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
        case (state)
          SEARCH: begin
            if (comma) begin
              bit_cnt   <= 4'd1;
              comma_cnt <= CW'(1);
              out_q     <= sreg;
              valid_q   <= 1'b1;
              det_q     <= 1'b1;
              // A single-comma lock requirement is met by this very comma.
              if (LOCK_CNT <= 1) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                err_cnt  <= '0;
              end else begin
                state <= ACQ;
              end
            end
          end
          ACQ: begin
            if (aligned) begin
              out_q   <= sreg;
              valid_q <= 1'b1;
              det_q   <= comma;
              if (comma) begin
                comma_cnt <= comma_nxt;
                if (comma_nxt >= LOCK_MAX) begin
                  state    <= LOCKED;
                  locked_q <= 1'b1;
                  err_cnt  <= '0;
                end
              end
            end else if (comma) begin
              // Not yet trusted: follow the newer comma and restart the count.
              bit_cnt   <= 4'd1;
              comma_cnt <= CW'(1);
              out_q     <= sreg;
              valid_q   <= 1'b1;
              det_q     <= 1'b1;
            end
          end
          LOCKED: begin
            if (aligned) begin
              out_q   <= sreg;
              valid_q <= 1'b1;
              det_q   <= comma;
              if (comma) begin
                err_cnt <= '0;
              end
            end else if (comma) begin
              // Locked alignment is kept; misplaced commas are only counted.
              err_cnt <= err_nxt;
              if (err_nxt >= LOSS_MAX) begin
                state     <= SEARCH;
                locked_q  <= 1'b0;
                comma_cnt <= '0;
                err_cnt   <= '0;
              end
            end
          end
          default: begin
            state    <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
